// File: rtl/nic_pkg.sv
// nic_pkg: shared types and constants for the NIC transfer controller.
// Latency: none, holds no logic (state encoding, NIC register map, status bit).
// Backpressure: not applicable; imported by nic_xfer_ctrl.
package nic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_OSTAT,
    CHK_OSTAT,
    WR_PKT,
    RD_ISTAT,
    CHK_ISTAT,
    RD_IBUF,
    CAP_IBUF,
    BACKOFF
  } state_t;

  // Which service path was entered most recently, used for round-robin.
  typedef enum logic {
    PATH_TX = 1'b0,
    PATH_RX = 1'b1
  } path_t;

  // NIC register map.
  localparam logic [1:0] NIC_OUT_BUF  = 2'b00;
  localparam logic [1:0] NIC_OUT_STAT = 2'b01;
  localparam logic [1:0] NIC_IN_BUF   = 2'b10;
  localparam logic [1:0] NIC_IN_STAT  = 2'b11;

  // Status flag position inside the 64-bit NIC data word.
  localparam int STAT_BIT = 63;

endpackage

// File: rtl/nic_xfer_ctrl.sv
// nic_xfer_ctrl: drives the NIC register port, polling status then writing tx / reading rx, round-robin.
// Latency: tx_ready 3 cycles after tx_valid is taken in IDLE; rx_valid 5 cycles after an RX poll starts.
// Backpressure: requester holds tx until the tx_ready pulse; single rx slot, no RX poll while rx_valid.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   tx_valid/tx_data     outbound packet from requester, tx_ready is a one-cycle accept
//   rx_valid/rx_data     inbound packet slot, emptied by rx_valid && rx_ready
//   nic_addr/nic_d_in    NIC register select and write data
//   nic_en/nic_wr_en     NIC access / write strobes; nic_d_out returns read data one cycle later
//   busy                 controller is not in IDLE
//   tx_cnt/rx_cnt        wrapping packet counters
module nic_xfer_ctrl
  import nic_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int POLL_IDLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [0:63]      tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [0:63]      rx_data,
  input  logic             rx_ready,
  output logic [0:1]       nic_addr,
  output logic [0:63]      nic_d_in,
  output logic             nic_en,
  output logic             nic_wr_en,
  input  logic [0:63]      nic_d_out,
  output logic             busy,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt
);

  // Counter holds POLL_IDLE-1 .. 0 so that BACKOFF lasts exactly POLL_IDLE cycles.
  localparam int BO_W = $clog2(POLL_IDLE + 2);
  localparam logic [BO_W-1:0] BO_LOAD = BO_W'((POLL_IDLE > 0) ? (POLL_IDLE - 1) : 0);
  // A poll that misses either backs off or, with no back-off configured, returns straight to IDLE.
  localparam state_t MISS_ST = (POLL_IDLE == 0) ? IDLE : BACKOFF;

  state_t          state;
  state_t          state_nxt;
  path_t           last;
  logic [BO_W-1:0] bo_cnt;
  logic            stat_set;
  logic            acc;

  // Status read issued in RD_* comes back on nic_d_out during the following CHK_* cycle.
  assign stat_set = nic_d_out[STAT_BIT];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (tx_valid && (last == PATH_RX || rx_valid)) begin
          state_nxt = RD_OSTAT;
        end else if (!rx_valid) begin
          state_nxt = RD_ISTAT;
        end
      end
      RD_OSTAT:  state_nxt = CHK_OSTAT;
      CHK_OSTAT: state_nxt = stat_set ? MISS_ST : WR_PKT;
      WR_PKT:    state_nxt = IDLE;
      RD_ISTAT:  state_nxt = CHK_ISTAT;
      CHK_ISTAT: state_nxt = stat_set ? RD_IBUF : MISS_ST;
      RD_IBUF:   state_nxt = CAP_IBUF;
      CAP_IBUF:  state_nxt = IDLE;
      BACKOFF:   if (bo_cnt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Moore-decoded NIC port; non-access states park everything at zero.
  always_comb begin
    acc       = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = NIC_OUT_BUF;
    nic_d_in  = '0;
    unique case (state)
      RD_OSTAT: begin
        acc      = 1'b1;
        nic_addr = NIC_OUT_STAT;
      end
      WR_PKT: begin
        acc       = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = NIC_OUT_BUF;
        nic_d_in  = tx_data;
      end
      RD_ISTAT: begin
        acc      = 1'b1;
        nic_addr = NIC_IN_STAT;
      end
      RD_IBUF: begin
        acc      = 1'b1;
        nic_addr = NIC_IN_BUF;
      end
      default: begin
        acc = 1'b0;
      end
    endcase
  end

  // Gating with reset keeps a reset in WR_PKT from accepting or writing a packet.
  assign nic_en   = acc && !reset;
  assign tx_ready = (state == WR_PKT) && !reset;
  assign busy     = (state != IDLE);

  // Arbitration bit, back-off counter, counters and rx slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= PATH_RX;
      bo_cnt   <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      // Every path returns through IDLE before the next arbitration, so recording the
      // path at entry is equivalent to recording it at completion, and a missed poll
      // still counts as a turn for that path.
      if (state == IDLE && state_nxt == RD_OSTAT) last <= PATH_TX;
      if (state == IDLE && state_nxt == RD_ISTAT) last <= PATH_RX;

      if (state_nxt == BACKOFF && state != BACKOFF) begin
        bo_cnt <= BO_LOAD;
      end else if (state == BACKOFF && bo_cnt != '0) begin
        bo_cnt <= bo_cnt - 1'b1;
      end

      if (state == WR_PKT) tx_cnt <= tx_cnt + 1'b1;

      // Capture and consumer clear cannot coincide: CAP_IBUF is only reached with the slot empty.
      if (state == CAP_IBUF) begin
        rx_data  <= nic_d_out;
        rx_valid <= 1'b1;
        rx_cnt   <= rx_cnt + 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nic_xfer_ctrl.sv
// tb_nic_xfer_ctrl: directed bench for nic_xfer_ctrl with a NIC register model and a transaction scoreboard.
// Latency: literal cycle expectations for send/receive sequences; scoreboard checks every cycle.
// Backpressure: requester holds tx until tx_ready; consumer rx_ready driven per test.
module tb_nic_xfer_ctrl;

  localparam int CNT_W     = 4;
  localparam int POLL_IDLE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             tx_valid;
  logic [0:63]      tx_data;
  logic             tx_ready;
  logic             rx_valid;
  logic [0:63]      rx_data;
  logic             rx_ready;
  logic [0:1]       nic_addr;
  logic [0:63]      nic_d_in;
  logic             nic_en;
  logic             nic_wr_en;
  logic [0:63]      nic_d_out;
  logic             busy;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;

  nic_xfer_ctrl #(.CNT_W(CNT_W), .POLL_IDLE(POLL_IDLE)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_en(nic_en), .nic_wr_en(nic_wr_en),
    .nic_d_out(nic_d_out), .busy(busy), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // NIC configuration, written by the stimulus only.
  int          ostat_busy_until = 0;  // out-status reads below this index report full
  int          in_posted = 0;         // in-buffer packets made available so far
  logic        in_sticky = 1'b0;      // in-status always reports a packet
  logic [0:63] in_buf = '0;

  // NIC state, written by the NIC model only.
  int ostat_rds = 0;
  int in_reads  = 0;

  // Requester bookkeeping.
  logic [63:0] tx_base;
  int          tx_sent;
  int          tx_limit;

  // Per-test scratch.
  int first_rdy, idle_n, ostat_n, en_n, n_ev;
  int ev[8];

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  // NIC register model: read data returned the cycle after the access; reading the
  // in-buffer consumes the posted packet; undriven cycles return all-ones.
  always @(posedge clk) begin
    if (nic_en && !nic_wr_en) begin
      case (nic_addr)
        2'b01: begin
          nic_d_out <= (ostat_rds < ostat_busy_until) ? 64'd1 : 64'd0;
          ostat_rds <= ostat_rds + 1;
        end
        2'b11: nic_d_out <= (in_sticky || in_reads < in_posted) ? 64'd1 : 64'd0;
        2'b10: begin
          nic_d_out <= in_buf;
          if (in_reads < in_posted) in_reads <= in_reads + 1;
        end
        default: nic_d_out <= '1;
      endcase
    end else begin
      nic_d_out <= '1;
    end
  end

  // Scoreboard: counters, rx slot contents and NIC-port protocol rules, every cycle.
  task automatic monitor();
    logic [CNT_W-1:0] m_tx, m_rx;
    logic             m_rv, cap_pend, ostat_ok, istat_ok;
    logic [0:63]      m_rd, cap_data;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_tx_ready_gated", 64'(tx_ready), 64'd0);
        chk("rst_nic_en_gated", 64'(nic_en), 64'd0);
        m_tx = '0; m_rx = '0; m_rv = 1'b0; m_rd = '0;
        cap_pend = 1'b0; cap_data = '0; ostat_ok = 1'b0; istat_ok = 1'b0;
      end else begin
        chk("mon_tx_cnt", 64'(tx_cnt), 64'(m_tx));
        chk("mon_rx_cnt", 64'(rx_cnt), 64'(m_rx));
        chk("mon_rx_valid", 64'(rx_valid), 64'(m_rv));
        chk("mon_rx_data", 64'(rx_data), 64'(m_rd));
        if (!nic_en) begin
          chk("mon_idle_wr_en", 64'(nic_wr_en), 64'd0);
          chk("mon_idle_addr", 64'(nic_addr), 64'd0);
          chk("mon_idle_d_in", 64'(nic_d_in), 64'd0);
        end else begin
          chk("mon_busy_on_access", 64'(busy), 64'd1);
        end
        if (tx_ready) begin
          chk("mon_wr_en_on_accept", 64'(nic_en && nic_wr_en), 64'd1);
          chk("mon_wr_addr", 64'(nic_addr), 64'd0);
          chk("mon_wr_data", 64'(nic_d_in), 64'(tx_data));
          chk("mon_write_after_ok_poll", 64'(ostat_ok), 64'd1);
          m_tx     = m_tx + 1'b1;
          ostat_ok = 1'b0;
        end
        if (m_rv && rx_ready) m_rv = 1'b0;
        if (cap_pend) begin
          m_rv = 1'b1; m_rd = cap_data; m_rx = m_rx + 1'b1; cap_pend = 1'b0;
        end
        if (nic_en && !nic_wr_en && nic_addr == 2'b10) begin
          chk("mon_ibuf_after_ok_poll", 64'(istat_ok), 64'd1);
          chk("mon_ibuf_slot_empty", 64'(m_rv), 64'd0);
          cap_pend = 1'b1; cap_data = in_buf; istat_ok = 1'b0;
        end
        if (nic_en && !nic_wr_en && nic_addr == 2'b01) ostat_ok = !(ostat_rds < ostat_busy_until);
        if (nic_en && !nic_wr_en && nic_addr == 2'b11) istat_ok = in_sticky || (in_reads < in_posted);
      end
    end
  endtask

  // Move from a sample point to the next drive point, advancing the requester on accept.
  task automatic adv();
    logic r;
    r = tx_ready;
    @(posedge clk);
    #1;
    if (r) begin
      tx_sent++;
      tx_data = tx_base + 64'(tx_sent);
      if (tx_sent >= tx_limit) tx_valid = 1'b0;
    end
  endtask

  task automatic tick();
    adv();
    @(negedge clk);
  endtask

  // Two reset cycles with reset-state checks; returns at a drive point with reset still high.
  task automatic rst_begin();
    adv();
    reset = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0; in_sticky = 1'b0;
    in_posted = in_reads; ostat_busy_until = ostat_rds;
    @(negedge clk);
    adv();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_rx_data", 64'(rx_data), 64'd0);
    chk("rst_tx_cnt", 64'(tx_cnt), 64'd0);
    chk("rst_rx_cnt", 64'(rx_cnt), 64'd0);
    chk("rst_nic_en", 64'(nic_en), 64'd0);
    chk("rst_nic_wr_en", 64'(nic_wr_en), 64'd0);
    chk("rst_nic_addr", 64'(nic_addr), 64'd0);
    chk("rst_nic_d_in", 64'(nic_d_in), 64'd0);
    adv();
    tx_sent = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    tx_base = '0; tx_sent = 0; tx_limit = 0;
    fork monitor(); join_none
    @(negedge clk);

    // Single send with the out buffer free.
    rst_begin();
    reset = 1'b0; tx_base = 64'hA5A5_0000_0000_0001; tx_data = tx_base; tx_limit = 1; tx_valid = 1'b1;
    @(negedge clk);
    chk("send_c0_idle", 64'(busy), 64'd0);
    tick();
    chk("send_c1_en", 64'(nic_en), 64'd1);
    chk("send_c1_addr", 64'(nic_addr), 64'd1);
    chk("send_c1_wr_en", 64'(nic_wr_en), 64'd0);
    tick();
    chk("send_c2_en", 64'(nic_en), 64'd0);
    chk("send_c2_busy", 64'(busy), 64'd1);
    tick();
    chk("send_c3_tx_ready", 64'(tx_ready), 64'd1);
    chk("send_c3_wr_en", 64'(nic_wr_en), 64'd1);
    chk("send_c3_addr", 64'(nic_addr), 64'd0);
    chk("send_c3_d_in", 64'(nic_d_in), 64'hA5A5_0000_0000_0001);
    tick();
    chk("send_c4_tx_ready", 64'(tx_ready), 64'd0);
    chk("send_c4_tx_cnt", 64'(tx_cnt), 64'd1);
    chk("send_c4_idle", 64'(busy), 64'd0);

    // Out buffer full for three polls; rounds are TX poll + back-off, RX poll + back-off.
    rst_begin();
    ostat_busy_until = ostat_rds + 3;
    reset = 1'b0; tx_base = 64'h0F0F_0000_0000_0010; tx_data = tx_base; tx_limit = 1; tx_valid = 1'b1;
    @(negedge clk);
    first_rdy = -1; idle_n = 0; ostat_n = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_ready && first_rdy < 0) first_rdy = c;
      if (first_rdy < 0 && !busy) idle_n++;
      if (nic_en && nic_addr == 2'b01) ostat_n++;
      tick();
    end
    chk("full_first_accept_cycle", 64'(first_rdy), 64'd45);
    chk("full_idle_cycles_before_write", 64'(idle_n), 64'd7);
    chk("full_out_status_polls", 64'(ostat_n), 64'd4);
    chk("full_tx_cnt", 64'(tx_cnt), 64'd1);

    // Receive one packet; slot stays full until rx_ready.
    rst_begin();
    in_buf = 64'hDEAD_BEEF_0000_0042; in_posted = in_reads + 1;
    reset = 1'b0;
    @(negedge clk);
    chk("recv_c0_idle", 64'(busy), 64'd0);
    tick();
    chk("recv_c1_en", 64'(nic_en), 64'd1);
    chk("recv_c1_addr", 64'(nic_addr), 64'd3);
    tick();
    chk("recv_c2_en", 64'(nic_en), 64'd0);
    tick();
    chk("recv_c3_en", 64'(nic_en), 64'd1);
    chk("recv_c3_addr", 64'(nic_addr), 64'd2);
    tick();
    chk("recv_c4_rx_valid", 64'(rx_valid), 64'd0);
    tick();
    chk("recv_c5_rx_valid", 64'(rx_valid), 64'd1);
    chk("recv_c5_rx_data", 64'(rx_data), 64'hDEAD_BEEF_0000_0042);
    chk("recv_c5_rx_cnt", 64'(rx_cnt), 64'd1);
    en_n = 0;
    repeat (10) begin
      tick();
      if (nic_en) en_n++;
    end
    chk("recv_no_poll_while_full", 64'(en_n), 64'd0);
    chk("recv_slot_held", 64'(rx_valid), 64'd1);
    adv();
    rx_ready = 1'b1;
    @(negedge clk);
    chk("recv_valid_during_ready", 64'(rx_valid), 64'd1);
    adv();
    rx_ready = 1'b0;
    @(negedge clk);
    chk("recv_cleared", 64'(rx_valid), 64'd0);

    // Contention: TX held, RX always pending, NIC always ready -> strict alternation from TX.
    rst_begin();
    in_sticky = 1'b1; in_buf = 64'h1234_5678_9ABC_DEF0; rx_ready = 1'b1;
    reset = 1'b0; tx_base = 64'hC0DE_0000_0000_0000; tx_data = tx_base; tx_limit = 100; tx_valid = 1'b1;
    @(negedge clk);
    n_ev = 0;
    for (int c = 0; c < 80 && n_ev < 6; c++) begin
      if (tx_ready && n_ev < 8) begin ev[n_ev] = 1; n_ev++; end
      if (nic_en && !nic_wr_en && nic_addr == 2'b10 && n_ev < 8) begin ev[n_ev] = 2; n_ev++; end
      tick();
    end
    chk("cont_event_count", 64'(n_ev), 64'd6);
    for (int i = 0; i < 6; i++) chk("cont_order", 64'(ev[i]), (i % 2 == 0) ? 64'd1 : 64'd2);

    // Reset during WR_PKT: no accept, packet stays with the requester and is sent later.
    rst_begin();
    reset = 1'b0; tx_base = 64'h5555_AAAA_0000_0003; tx_data = tx_base; tx_limit = 1; tx_valid = 1'b1;
    @(negedge clk);
    tick();
    tick();
    adv();
    reset = 1'b1;
    @(negedge clk);
    chk("rstwr_tx_ready", 64'(tx_ready), 64'd0);
    chk("rstwr_nic_en", 64'(nic_en), 64'd0);
    adv();
    @(negedge clk);
    chk("rstwr_busy", 64'(busy), 64'd0);
    chk("rstwr_tx_cnt", 64'(tx_cnt), 64'd0);
    chk("rstwr_wr_en", 64'(nic_wr_en), 64'd0);
    chk("rstwr_d_in", 64'(nic_d_in), 64'd0);
    adv();
    reset = 1'b0;
    @(negedge clk);
    repeat (10) tick();
    chk("rstwr_resent_tx_cnt", 64'(tx_cnt), 64'd1);

    // Reset during RD_IBUF: in-buffer read is discarded.
    rst_begin();
    in_buf = 64'h0BAD_F00D_0000_0007; in_posted = in_reads + 1;
    reset = 1'b0;
    @(negedge clk);
    tick();
    tick();
    adv();
    reset = 1'b1;
    @(negedge clk);
    chk("rstib_nic_en", 64'(nic_en), 64'd0);
    chk("rstib_tx_ready", 64'(tx_ready), 64'd0);
    adv();
    @(negedge clk);
    chk("rstib_rx_valid", 64'(rx_valid), 64'd0);
    chk("rstib_rx_cnt", 64'(rx_cnt), 64'd0);
    chk("rstib_rx_data", 64'(rx_data), 64'd0);
    chk("rstib_busy", 64'(busy), 64'd0);

    // Counter wrap: 17 sends on a 4-bit counter.
    rst_begin();
    reset = 1'b0; tx_base = 64'h7700_0000_0000_0000; tx_data = tx_base; tx_limit = 17; tx_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 600 && tx_sent < 17; c++) tick();
    chk("wrap_sends_done", 64'(tx_sent), 64'd17);
    tick();
    tick();
    chk("wrap_tx_cnt", 64'(tx_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
